// File: rtl/pixel_expand_pkg.sv
// Shared VRAM pixel definitions: BGR555 field layout, packed pixel and
// expanded colour types, and the unpack-buffer pending-mask encoding.
package pixel_expand_pkg;

   localparam int PIX_W    = 16;
   localparam int CH_W     = 5;
   localparam int R_LSB    = 0;
   localparam int G_LSB    = 5;
   localparam int B_LSB    = 10;
   localparam int MASK_BIT = 15;

   typedef struct packed {
      logic            mask;
      logic [CH_W-1:0] b;
      logic [CH_W-1:0] g;
      logic [CH_W-1:0] r;
   } pixel16;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb888;

   // Each bit marks a half-word of the buffered word still waiting for output.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      LOW   = 2'b01,
      HIGH  = 2'b10,
      BOTH  = 2'b11
   } pend_e;

   function automatic logic [1:0] lowest_bit(input logic [1:0] m);
      if (m[0])
         return 2'b01;
      else if (m[1])
         return 2'b10;
      else
         return 2'b00;
   endfunction

endpackage

// File: rtl/pixel_expand_expand555.sv
// Combinational BGR555 -> RGB888 expansion of one 16-bit VRAM pixel, plus
// mask bit and all-zero transparency flag.
module expand555
   import pixel_expand_pkg::*;
#(
   parameter int REPLICATE = 0
) (
   input  logic [PIX_W-1:0] pix,
   output rgb888            rgb,
   output logic             mask,
   output logic             transparent
);

   // Zero-fill matches the console exactly; replication maps full scale to 8'hFF.
   function automatic logic [7:0] widen(input logic [CH_W-1:0] c);
      if (REPLICATE != 0)
         return {c, c[CH_W-1 -: 3]};
      else
         return {c, 3'b000};
   endfunction

   assign rgb.r       = widen(pix[R_LSB +: CH_W]);
   assign rgb.g       = widen(pix[G_LSB +: CH_W]);
   assign rgb.b       = widen(pix[B_LSB +: CH_W]);
   assign mask        = pix[MASK_BIT];
   assign transparent = (pix == '0);

endmodule

// File: rtl/pixel_expand.sv
// VRAM read-path unpacker: splits 32-bit words into two BGR555 pixels and
// emits one expanded RGB888 pixel per cycle through a registered output.
module pixel_expand
   import pixel_expand_pkg::*;
#(
   parameter int REPLICATE = 0
) (
   input  logic        clk,
   input  logic        i_nRst,
   input  logic        i_flush,
   input  logic        i_wordValid,
   output logic        o_wordReady,
   input  logic [31:0] i_word,
   input  logic [1:0]  i_pixEn,
   output logic        o_pixValid,
   input  logic        i_pixReady,
   output logic [7:0]  o_r,
   output logic [7:0]  o_g,
   output logic [7:0]  o_b,
   output logic        o_mask,
   output logic        o_transparent,
   output logic        o_pixSel
);

   pend_e       pend;
   pend_e       pend_nxt;
   logic [31:0] word_p0;
   logic        out_adv;
   logic        load_pix;
   logic        sel_high;
   logic        word_fire;
   pixel16      pix_sel;
   rgb888       rgb_exp;
   logic        mask_exp;
   logic        transp_exp;

   always_ff @(posedge clk or negedge i_nRst) begin
      if (!i_nRst)
         pend <= EMPTY;
      else
         pend <= pend_nxt;
   end

   // Word buffer: data only, qualified by pend, so it carries no reset.
   always_ff @(posedge clk) begin
      if (word_fire)
         word_p0 <= i_word;
   end

   // A new word may land in the same cycle the last pending pixel leaves,
   // so the word load is applied after the bit clear.
   always_comb begin
      out_adv     = !o_pixValid || i_pixReady;
      load_pix    = out_adv && (pend != EMPTY);
      sel_high    = (pend == HIGH);
      o_wordReady = !i_flush &&
                    ((pend == EMPTY) || (((pend == LOW) || (pend == HIGH)) && out_adv));
      word_fire   = i_wordValid && o_wordReady;
      pend_nxt    = pend;
      if (load_pix)
         pend_nxt = pend_e'(pend & ~lowest_bit(pend));
      if (word_fire)
         pend_nxt = pend_e'(i_pixEn);
      if (i_flush)
         pend_nxt = EMPTY;
   end

   assign pix_sel = sel_high ? pixel16'(word_p0[31:16]) : pixel16'(word_p0[15:0]);

   expand555 #(
      .REPLICATE(REPLICATE)
   ) u_expand (
      .pix        (pix_sel),
      .rgb        (rgb_exp),
      .mask       (mask_exp),
      .transparent(transp_exp)
   );

   // Output stage p1: holds while stalled, flush drops the valid pixel.
   always_ff @(posedge clk or negedge i_nRst) begin
      if (!i_nRst) begin
         o_pixValid    <= 1'b0;
         o_r           <= '0;
         o_g           <= '0;
         o_b           <= '0;
         o_mask        <= 1'b0;
         o_transparent <= 1'b0;
         o_pixSel      <= 1'b0;
      end else if (i_flush) begin
         o_pixValid <= 1'b0;
      end else if (out_adv) begin
         o_pixValid <= load_pix;
         if (load_pix) begin
            o_r           <= rgb_exp.r;
            o_g           <= rgb_exp.g;
            o_b           <= rgb_exp.b;
            o_mask        <= mask_exp;
            o_transparent <= transp_exp;
            o_pixSel      <= sel_high;
         end
      end
   end

endmodule
